flag_status_unit: RTL and testbench

- Holds the architectural NZCV status register and supplies it to the condition-check stage in ID.
- Tracks flag-setting instructions in flight between ID and the flag write point, and raises a flag hazard stall when a conditional instruction would otherwise read stale flags.
- Optionally forwards ALU flags straight to the condition check.
- Provides a one-deep saved copy (SPSR) for exception entry and return.

---
 rtl/flag_status_unit.sv | 81 ++++++++
 tb/tb_flag_status_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/flag_status_unit.sv
// NZCV status register with forwarding to the ID condition check, a hazard tracker
// for in-flight flag setters, a one-deep SPSR and a saturating flag-write counter.
module flag_status_unit #(
    parameter bit FWD_EN     = 1'b1,
    parameter int PIPE_DEPTH = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_cond,
    input  logic             id_s,
    input  logic             stall,
    input  logic             flush,
    input  logic             exe_s_upd,
    input  logic [3:0]       alu_flags,
    input  logic             save,
    input  logic             restore,
    output logic [3:0]       sr,
    output logic [3:0]       sr_cc,
    output logic [3:0]       spsr,
    output logic             flag_hazard,
    output logic [CNT_W-1:0] upd_cnt
);

    // With forwarding, the entry in its write cycle is served by sr_cc and is not a hazard.
    localparam int CHK_DEPTH = FWD_EN ? PIPE_DEPTH - 1 : PIPE_DEPTH;

    logic [PIPE_DEPTH-1:0] pend;
    logic [PIPE_DEPTH-1:0] pend_next;
    logic                  need_flags;
    logic                  any_pend;
    logic                  insert;
    logic                  sr_write;

    assign need_flags  = id_valid & (id_cond <= 4'd13);
    assign flag_hazard = need_flags & any_pend;
    assign insert      = id_valid & id_s & ~stall & ~flag_hazard;
    assign sr_write    = exe_s_upd & ~restore;
    assign sr_cc       = (FWD_EN && sr_write) ? alu_flags : sr;

    always_comb begin
        any_pend = 1'b0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (k < CHK_DEPTH) begin
                any_pend = any_pend | pend[k];
            end
        end
    end

    always_comb begin
        pend_next    = pend << 1;
        pend_next[0] = insert;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend    <= '0;
            sr      <= 4'h0;
            spsr    <= 4'h0;
            upd_cnt <= '0;
        end else begin
            pend <= flush ? '0 : pend_next;

            if (restore) begin
                sr <= spsr;
            end else if (exe_s_upd) begin
                sr <= alu_flags;
            end

            if (save && !restore) begin
                spsr <= sr;
            end

            if (sr_write && (upd_cnt != '1)) begin
                upd_cnt <= upd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flag_status_unit.sv
// Drives five differently-parameterised flag_status_unit instances with shared stimulus
// and compares each against a queue-based behavioural model of the flag pipeline.
module tb_flag_status_unit;

    localparam int N = 5;
    localparam int FWD[N] = '{1, 0, 0, 1, 1};
    localparam int PD[N]  = '{1, 2, 3, 1, 3};
    localparam int CW[N]  = '{16, 16, 16, 2, 16};

    logic       clk = 1'b0;
    logic       rst, id_valid, id_s, stall, flush, exe_s_upd, save, restore;
    logic [3:0] id_cond, alu_flags;

    logic [3:0]  sr_o[N];
    logic [3:0]  cc_o[N];
    logic [3:0]  spsr_o[N];
    logic        hz_o[N];
    logic [15:0] cnt_o[N];
    logic [1:0]  cnt_d;

    int errors = 0;
    int checks = 0;

    // Behavioural model: per instance, ages of in-flight flag setters since issue.
    logic [3:0] m_sr[N];
    logic [3:0] m_spsr[N];
    int         m_cnt[N];
    int         ages[N][$];
    bit         model_ok = 1'b0;

    always #5 clk = ~clk;

    flag_status_unit #(.FWD_EN(1'b1), .PIPE_DEPTH(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_cond(id_cond), .id_s(id_s),
        .stall(stall), .flush(flush), .exe_s_upd(exe_s_upd), .alu_flags(alu_flags),
        .save(save), .restore(restore), .sr(sr_o[0]), .sr_cc(cc_o[0]), .spsr(spsr_o[0]),
        .flag_hazard(hz_o[0]), .upd_cnt(cnt_o[0]));

    flag_status_unit #(.FWD_EN(1'b0), .PIPE_DEPTH(2), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_cond(id_cond), .id_s(id_s),
        .stall(stall), .flush(flush), .exe_s_upd(exe_s_upd), .alu_flags(alu_flags),
        .save(save), .restore(restore), .sr(sr_o[1]), .sr_cc(cc_o[1]), .spsr(spsr_o[1]),
        .flag_hazard(hz_o[1]), .upd_cnt(cnt_o[1]));

    flag_status_unit #(.FWD_EN(1'b0), .PIPE_DEPTH(3), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_cond(id_cond), .id_s(id_s),
        .stall(stall), .flush(flush), .exe_s_upd(exe_s_upd), .alu_flags(alu_flags),
        .save(save), .restore(restore), .sr(sr_o[2]), .sr_cc(cc_o[2]), .spsr(spsr_o[2]),
        .flag_hazard(hz_o[2]), .upd_cnt(cnt_o[2]));

    flag_status_unit #(.FWD_EN(1'b1), .PIPE_DEPTH(1), .CNT_W(2)) u_d (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_cond(id_cond), .id_s(id_s),
        .stall(stall), .flush(flush), .exe_s_upd(exe_s_upd), .alu_flags(alu_flags),
        .save(save), .restore(restore), .sr(sr_o[3]), .sr_cc(cc_o[3]), .spsr(spsr_o[3]),
        .flag_hazard(hz_o[3]), .upd_cnt(cnt_d));

    assign cnt_o[3] = {14'b0, cnt_d};

    flag_status_unit #(.FWD_EN(1'b1), .PIPE_DEPTH(3), .CNT_W(16)) u_e (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_cond(id_cond), .id_s(id_s),
        .stall(stall), .flush(flush), .exe_s_upd(exe_s_upd), .alu_flags(alu_flags),
        .save(save), .restore(restore), .sr(sr_o[4]), .sr_cc(cc_o[4]), .spsr(spsr_o[4]),
        .flag_hazard(hz_o[4]), .upd_cnt(cnt_o[4]));

    task automatic check(input string tag, input int idx, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
        end
    endtask

    function automatic bit modelHazard(input int i);
        int lim = (FWD[i] != 0) ? PD[i] - 1 : PD[i];
        bit hz = 1'b0;
        if (id_valid && id_cond <= 4'd13) begin
            foreach (ages[i][j]) if (ages[i][j] < lim) hz = 1'b1;
        end
        return hz;
    endfunction

    function automatic logic [3:0] modelCc(input int i);
        if (FWD[i] != 0 && exe_s_upd && !restore) return alu_flags;
        return m_sr[i];
    endfunction

    task automatic applyStimulus(input logic r, input logic v, input logic [3:0] c,
                                 input logic s, input logic st, input logic fl,
                                 input logic u, input logic [3:0] a,
                                 input logic sv, input logic rs);
        rst = r; id_valid = v; id_cond = c; id_s = s; stall = st; flush = fl;
        exe_s_upd = u; alu_flags = a; save = sv; restore = rs;
    endtask

    // Compares every instance mid-cycle, away from the clock edge.
    task automatic checkOutput();
        @(negedge clk);
        if (model_ok) begin
            for (int i = 0; i < N; i++) begin
                check("sr", i, {12'b0, sr_o[i]}, {12'b0, m_sr[i]});
                check("spsr", i, {12'b0, spsr_o[i]}, {12'b0, m_spsr[i]});
                check("upd_cnt", i, cnt_o[i], 16'(m_cnt[i]));
                check("sr_cc", i, {12'b0, cc_o[i]}, {12'b0, modelCc(i)});
                check("flag_hazard", i, {15'b0, hz_o[i]}, {15'b0, modelHazard(i)});
            end
        end
    endtask

    // Applies the clock edge to the model, then lets the DUTs take the same edge.
    task automatic advance();
        for (int i = 0; i < N; i++) begin
            int nq[$];
            bit hz = modelHazard(i);
            if (!rst) begin
                m_sr[i] = 4'h0; m_spsr[i] = 4'h0; m_cnt[i] = 0; ages[i] = {};
            end else begin
                foreach (ages[i][j]) if (ages[i][j] + 1 < PD[i]) nq.push_back(ages[i][j] + 1);
                if (!flush && id_valid && id_s && !stall && !hz) nq.push_back(0);
                if (flush) nq = {};
                ages[i] = nq;
                if (save && !restore) m_spsr[i] = m_sr[i];
                if (restore) m_sr[i] = (save && !restore) ? m_sr[i] : m_spsr[i];
                else if (exe_s_upd) m_sr[i] = alu_flags;
                if (exe_s_upd && !restore && m_cnt[i] < (1 << CW[i]) - 1) m_cnt[i]++;
            end
        end
        if (!rst) model_ok = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        checkOutput();
        advance();
    endtask

    initial begin
        int cnt_before;
        applyStimulus(1'b0, 0, 4'd0, 0, 0, 0, 0, 4'h0, 0, 0);
        @(posedge clk);
        #1;

        // Reset holds everything at zero even with a flag write requested.
        applyStimulus(1'b0, 0, 4'd0, 0, 0, 0, 1, 4'hF, 0, 0);
        cycle();
        cycle();
        check("rst_sr", 0, {12'b0, sr_o[0]}, 16'h0);
        check("rst_spsr", 0, {12'b0, spsr_o[0]}, 16'h0);
        check("rst_cnt", 0, cnt_o[0], 16'h0);
        check("rst_hazard", 0, {15'b0, hz_o[0]}, 16'h0);
        applyStimulus(1'b1, 0, 4'd0, 0, 0, 0, 1, 4'hF, 0, 0);
        cycle();
        check("first_sr", 0, {12'b0, sr_o[0]}, 16'hF);
        check("first_cnt", 0, cnt_o[0], 16'h1);

        // Forwarding on the FWD_EN=1, PIPE_DEPTH=1 instance.
        applyStimulus(1'b1, 0, 4'd0, 0, 0, 0, 1, 4'h0, 0, 0);
        cycle();
        applyStimulus(1'b1, 1, 4'd0, 0, 0, 0, 1, 4'b0100, 0, 0);
        checkOutput();
        check("fwd_cc", 0, {12'b0, cc_o[0]}, 16'h4);
        check("fwd_hazard", 0, {15'b0, hz_o[0]}, 16'h0);
        check("nofwd_cc", 1, {12'b0, cc_o[1]}, 16'h0);
        advance();
        check("fwd_sr", 0, {12'b0, sr_o[0]}, 16'h4);

        // Hazard window on the FWD_EN=0, PIPE_DEPTH=2 instance.
        applyStimulus(1'b1, 1, 4'd14, 1, 0, 0, 0, 4'h0, 0, 0);
        cycle();
        applyStimulus(1'b1, 1, 4'd1, 0, 0, 0, 0, 4'h0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            checkOutput();
            check("hz_window", 1, {15'b0, hz_o[1]}, (k < 2) ? 16'h1 : 16'h0);
            advance();
        end
        applyStimulus(1'b1, 1, 4'd14, 1, 0, 0, 0, 4'h0, 0, 0);
        cycle();
        applyStimulus(1'b1, 1, 4'd14, 0, 0, 0, 0, 4'h0, 0, 0);
        checkOutput();
        check("hz_always", 1, {15'b0, hz_o[1]}, 16'h0);
        advance();

        // Flush on the FWD_EN=0, PIPE_DEPTH=3 instance.
        applyStimulus(1'b1, 0, 4'd0, 0, 0, 0, 0, 4'h0, 0, 0);
        repeat (3) cycle();
        applyStimulus(1'b1, 1, 4'd14, 1, 0, 0, 0, 4'h0, 0, 0);
        cycle();
        applyStimulus(1'b1, 0, 4'd0, 0, 0, 1, 0, 4'h0, 0, 0);
        cycle();
        applyStimulus(1'b1, 1, 4'd4, 0, 0, 0, 0, 4'h0, 0, 0);
        checkOutput();
        check("flush_hazard", 2, {15'b0, hz_o[2]}, 16'h0);
        advance();

        // Save / restore sequence.
        applyStimulus(1'b1, 0, 4'd0, 0, 0, 0, 1, 4'b1010, 0, 0);
        cycle();
        applyStimulus(1'b1, 0, 4'd0, 0, 0, 0, 0, 4'h0, 1, 0);
        cycle();
        check("save_spsr", 0, {12'b0, spsr_o[0]}, 16'hA);
        applyStimulus(1'b1, 0, 4'd0, 0, 0, 0, 1, 4'b0001, 0, 0);
        cycle();
        check("write_sr", 0, {12'b0, sr_o[0]}, 16'h1);
        cnt_before = int'(cnt_o[0]);
        applyStimulus(1'b1, 0, 4'd0, 0, 0, 0, 1, 4'hF, 0, 1);
        cycle();
        check("restore_sr", 0, {12'b0, sr_o[0]}, 16'hA);
        check("restore_cc", 0, {12'b0, cc_o[0]}, 16'hA);
        check("restore_cnt", 0, cnt_o[0], 16'(cnt_before));
        applyStimulus(1'b1, 0, 4'd0, 0, 0, 0, 1, 4'h5, 1, 1);
        cycle();
        check("save_restore_spsr", 0, {12'b0, spsr_o[0]}, 16'hA);

        // Counter saturation on the CNT_W=2 instance.
        applyStimulus(1'b0, 0, 4'd0, 0, 0, 0, 0, 4'h0, 0, 0);
        cycle();
        applyStimulus(1'b1, 0, 4'd0, 0, 0, 0, 1, 4'h3, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("sat_cnt", 3, cnt_o[3], (k < 3) ? 16'(k + 1) : 16'h3);
        end

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 59) != 0, 1'($urandom), 4'($urandom),
                          1'($urandom), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) == 0, 1'($urandom), 4'($urandom),
                          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
